// File: rtl/pixel_threshold_binarizer_if.sv
// Pixel-stream bundle between the memory reader and the binarizer, plus the
// binarizer's result signals toward the binary-image sink.
interface pixel_threshold_binarizer_if;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       restart;
    logic       bin_out;
    logic       bin_valid;
    logic [7:0] threshold;
    logic       thr_valid;
    logic       frame_done;
    logic       busy;

    modport master (
        output pix_in, pix_valid, restart,
        input  bin_out, bin_valid, threshold, thr_valid, frame_done, busy
    );

    modport slave (
        input  pix_in, pix_valid, restart,
        output bin_out, bin_valid, threshold, thr_valid, frame_done, busy
    );
endinterface

// File: rtl/pixel_threshold_binarizer.sv
// Two-pass global-threshold binarizer: pass 1 derives a threshold (mean or
// mid-range), pass 2 emits one binary pixel per input pixel.
module pixel_threshold_binarizer #(
    parameter int NUM_PIXELS  = 16384,
    parameter int LOG2_PIXELS = 14,
    parameter int MODE        = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    pixel_threshold_binarizer_if.slave    bus
);
    localparam int SUM_W = LOG2_PIXELS + 8;
    localparam logic [LOG2_PIXELS-1:0] CNT_LAST = LOG2_PIXELS'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {ACCUM, BINARIZE, DONE} state_e;

    state_e                 state_q;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [LOG2_PIXELS-1:0] cnt_q, cnt_d;
    logic [7:0]             pmin_q, pmin_d;
    logic [7:0]             pmax_q, pmax_d;
    logic [8:0]             mid_d;
    logic [7:0]             threshold_q, thr_d;
    logic                   thr_valid_q;
    logic                   bin_out_q;
    logic                   bin_valid_q;
    logic                   frame_done_q;
    logic                   busy_q;
    logic                   last_pix;

    // Threshold candidates include the pixel being sampled, so the final
    // pass-1 pixel contributes on the same edge the threshold is latched.
    assign sum_d    = sum_q + SUM_W'(bus.pix_in);
    assign cnt_d    = cnt_q + LOG2_PIXELS'(1);
    assign pmin_d   = (bus.pix_in < pmin_q) ? bus.pix_in : pmin_q;
    assign pmax_d   = (bus.pix_in > pmax_q) ? bus.pix_in : pmax_q;
    assign mid_d    = {1'b0, pmin_d} + {1'b0, pmax_d};
    assign thr_d    = (MODE == 1) ? 8'(mid_d >> 1) : 8'(sum_d >> LOG2_PIXELS);
    assign last_pix = (cnt_q == CNT_LAST);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ACCUM;
            sum_q        <= '0;
            cnt_q        <= '0;
            pmin_q       <= 8'hFF;
            pmax_q       <= 8'h00;
            threshold_q  <= 8'h00;
            thr_valid_q  <= 1'b0;
            bin_out_q    <= 1'b0;
            bin_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            bin_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.restart) begin
                // Restart beats a coincident pixel; threshold survives until overwritten.
                state_q     <= ACCUM;
                sum_q       <= '0;
                cnt_q       <= '0;
                pmin_q      <= 8'hFF;
                pmax_q      <= 8'h00;
                thr_valid_q <= 1'b0;
                busy_q      <= 1'b1;
            end else begin
                case (state_q)
                    ACCUM: begin
                        if (bus.pix_valid) begin
                            sum_q  <= sum_d;
                            pmin_q <= pmin_d;
                            pmax_q <= pmax_d;
                            cnt_q  <= cnt_d;
                            if (last_pix) begin
                                threshold_q <= thr_d;
                                thr_valid_q <= 1'b1;
                                state_q     <= BINARIZE;
                            end
                        end
                    end
                    BINARIZE: begin
                        if (bus.pix_valid) begin
                            bin_out_q   <= (bus.pix_in >= threshold_q);
                            bin_valid_q <= 1'b1;
                            cnt_q       <= cnt_d;
                            if (last_pix) begin
                                state_q      <= DONE;
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.bin_out    = bin_out_q;
    assign bus.bin_valid  = bin_valid_q;
    assign bus.threshold  = threshold_q;
    assign bus.thr_valid  = thr_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_pixel_threshold_binarizer.sv
// Directed bench: a MODE 0 and a MODE 1 binarizer (256-pixel frames) fed the
// same stream, checked against hand-computed thresholds and pixel results.
module tb_pixel_threshold_binarizer;
    localparam int NP = 256;
    localparam int LP = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    pixel_threshold_binarizer_if if0 ();
    pixel_threshold_binarizer_if if1 ();

    pixel_threshold_binarizer #(.NUM_PIXELS(NP), .LOG2_PIXELS(LP), .MODE(0)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if0.slave)
    );

    pixel_threshold_binarizer #(.NUM_PIXELS(NP), .LOG2_PIXELS(LP), .MODE(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if1.slave)
    );

    typedef struct {
        logic [7:0] pix;
        logic       exp_mode0;
        logic       exp_mode1;
    } vec_t;

    vec_t vecs[8];

    int errors = 0;
    int checks = 0;
    int bv_cnt, one_cnt, fd_cnt, fd_misaligned, bad_bin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        bv_cnt = 0; one_cnt = 0; fd_cnt = 0; fd_misaligned = 0; bad_bin = 0;
    endtask

    // Drive one cycle at the falling edge; observe the result one edge later.
    task automatic step(input logic [7:0] p, input logic v, input logic r);
        if0.pix_in = p; if0.pix_valid = v; if0.restart = r;
        if1.pix_in = p; if1.pix_valid = v; if1.restart = r;
        @(negedge clock);
        if (if0.bin_valid) begin
            bv_cnt++;
            if (if0.bin_out) one_cnt++;
        end
        if (if0.frame_done) begin
            fd_cnt++;
            if (!if0.bin_valid) fd_misaligned++;
        end
        if0.pix_valid = 1'b0; if0.restart = 1'b0;
        if1.pix_valid = 1'b0; if1.restart = 1'b0;
    endtask

    task automatic send(input logic [7:0] p, input int gap);
        step(p, 1'b1, 1'b0);
        repeat (gap) step(8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_restart();
        step(8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h0F, 1'b0, 1'b0};
        vecs[2] = '{8'h10, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hF0, 1'b1, 1'b1};
        vecs[7] = '{8'hFF, 1'b1, 1'b1};

        if0.pix_in = 8'h00; if0.pix_valid = 1'b0; if0.restart = 1'b0;
        if1.pix_in = 8'h00; if1.pix_valid = 1'b0; if1.restart = 1'b0;

        // Reset values
        #12;
        check("rst_bin_out",    if0.bin_out,    0);
        check("rst_bin_valid",  if0.bin_valid,  0);
        check("rst_threshold",  if0.threshold,  0);
        check("rst_thr_valid",  if0.thr_valid,  0);
        check("rst_frame_done", if0.frame_done, 0);
        check("rst_busy",       if0.busy,       1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // A: all 0x80, one strobe every two cycles
        clear_counts();
        for (int i = 0; i < NP; i++) send(8'h80, 1);
        check("a_pass1_no_bin", bv_cnt, 0);
        check("a_threshold", if0.threshold, 8'h80);
        check("a_thr_valid", if0.thr_valid, 1);
        check("a_busy_pass2", if0.busy, 1);
        clear_counts();
        for (int i = 0; i < NP; i++) send(8'h80, 1);
        check("a_bin_valid_cnt", bv_cnt, NP);
        check("a_ones_cnt", one_cnt, NP);
        check("a_frame_done_cnt", fd_cnt, 1);
        check("a_frame_done_aligned", fd_misaligned, 0);
        check("a_busy_done", if0.busy, 0);
        clear_counts();
        repeat (5) send(8'h80, 0);
        check("a_done_no_bin", bv_cnt, 0);
        check("a_done_no_fd", fd_cnt, 0);
        do_restart();
        check("a_rst_thr_valid", if0.thr_valid, 0);
        check("a_rst_busy", if0.busy, 1);
        check("a_rst_thr_hold", if0.threshold, 8'h80);

        // B: ramp, back-to-back
        for (int i = 0; i < NP; i++) send(8'(i), 0);
        check("b_threshold_m0", if0.threshold, 8'h7F);
        check("b_threshold_m1", if1.threshold, 8'h7F);
        clear_counts();
        for (int i = 0; i < NP; i++) begin
            send(8'(i), 0);
            if (if0.bin_out !== ((i & 255) >= 127)) bad_bin++;
        end
        check("b_bin_per_pixel", bad_bin, 0);
        check("b_ones_cnt", one_cnt, 129);
        check("b_bin_valid_cnt", bv_cnt, NP);
        check("b_frame_done_cnt", fd_cnt, 1);
        do_restart();

        // C: 0x10 everywhere except one 0xF0; table applied right after pass 1
        for (int i = 0; i < NP; i++) send((i == 100) ? 8'hF0 : 8'h10, 0);
        check("c_threshold_m0", if0.threshold, 8'h10);
        check("c_threshold_m1", if1.threshold, 8'h80);
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].pix, 0);
            check($sformatf("c_vec%0d_valid", i), if0.bin_valid, 1);
            check($sformatf("c_vec%0d_m0", i), if0.bin_out, vecs[i].exp_mode0);
            check($sformatf("c_vec%0d_m1", i), if1.bin_out, vecs[i].exp_mode1);
        end
        for (int i = 8; i < NP; i++) send(8'h00, 0);
        check("c_bin_valid_cnt", bv_cnt, NP);
        check("c_frame_done_cnt", fd_cnt, 1);
        do_restart();

        // D: back-to-back boundary, then restart with a coincident pixel
        for (int i = 0; i < NP; i++) send(8'h80, 0);
        send(8'h80, 0);
        check("d_first_valid", if0.bin_valid, 1);
        check("d_first_bin", if0.bin_out, 1);
        for (int i = 1; i < 100; i++) send(8'h80, 0);
        step(8'h80, 1'b1, 1'b1);
        check("d_restart_no_bin", if0.bin_valid, 0);
        check("d_restart_thr_valid", if0.thr_valid, 0);
        check("d_restart_busy", if0.busy, 1);
        check("d_restart_thr_hold", if0.threshold, 8'h80);
        for (int i = 0; i < NP - 1; i++) send(8'h20, 0);
        check("d_no_early_thr", if0.thr_valid, 0);
        send(8'h20, 0);
        check("d_thr_valid", if0.thr_valid, 1);
        check("d_threshold_m0", if0.threshold, 8'h20);
        check("d_threshold_m1", if1.threshold, 8'h20);

        // E: asynchronous reset in the middle of pass 1
        do_restart();
        for (int i = 0; i < 100; i++) send(8'h40, 1);
        #2 reset_n = 1'b0;
        #1;
        check("e_bin_out",    if0.bin_out,    0);
        check("e_bin_valid",  if0.bin_valid,  0);
        check("e_threshold",  if0.threshold,  0);
        check("e_thr_valid",  if0.thr_valid,  0);
        check("e_frame_done", if0.frame_done, 0);
        check("e_busy",       if0.busy,       1);
        #1 reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < NP - 1; i++) send(8'h40, 0);
        check("e_no_early_thr", if0.thr_valid, 0);
        send(8'h40, 0);
        check("e_threshold_new", if0.threshold, 8'h40);
        clear_counts();
        for (int i = 0; i < NP; i++) send(8'h40, 0);
        check("e_ones_cnt", one_cnt, NP);
        check("e_frame_done_cnt", fd_cnt, 1);
        clear_counts();
        repeat (4) send(8'hFF, 1);
        check("e_done_no_bin", bv_cnt, 0);
        check("e_done_no_fd", fd_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixel_threshold_binarizer.md
# pixel_threshold_binarizer

Two-pass mean/mid-range threshold binarizer that consumes the 8-bit grayscale pixel stream produced by the image memory reader. The image is streamed twice. Pass 1 computes a global threshold. Pass 2 emits one binary pixel per input pixel, compared against that threshold. It sits directly downstream of the memory reader and feeds the binary-image sink.

## Interface
- `NUM_PIXELS`, 16384: pixels per pass; must be a power of two.
- `LOG2_PIXELS`, 14: log2(`NUM_PIXELS`).
- `MODE`, 0: threshold rule. 0 = mean of all pixels; 1 = (min+max)>>1.
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pix_in` input 8: grayscale pixel from the memory reader.
- `pix_valid` input 1: one-cycle strobe; `pix_in` is sampled on the same edge.
- `restart` input 1: one-cycle pulse; abandons any frame and returns to pass 1.
- `bin_out` output 1: binary pixel; 1 when pixel ≥ threshold.
- `bin_valid` output 1: one-cycle strobe qualifying `bin_out`.
- `threshold` output 8: computed threshold; holds its value until the next pass 1 completes.
- `thr_valid` output 1: level; high from threshold computation until restart or reset.
- `frame_done` output 1: one-cycle pulse after the last pass-2 pixel.
- `busy` output 1: high in ACCUM and BINARIZE.

## Operation
- States: ACCUM, BINARIZE, DONE. Reset and `restart` both enter ACCUM.
- Internal registers:
  - `sum`: LOG2_PIXELS+8 bits (22 by default), unsigned, cannot overflow.
  - `cnt`: LOG2_PIXELS bits.
  - `pmin`: reset to 255.
  - `pmax`: reset to 0.

**ACCUM, on each `pix_valid`:**
- `sum += pix_in`; update `pmin` and `pmax`; `cnt += 1`.
- On the last pixel (`cnt == NUM_PIXELS-1`), the threshold is computed in the same edge and includes that pixel:
  - MODE 0: `threshold = (sum + pix_in) >> LOG2_PIXELS`, truncating.
  - MODE 1: `threshold = (min(pmin,pix_in) + max(pmax,pix_in)) >> 1`, using a 9-bit add, truncating.
- On that same edge: set `thr_valid`, clear `cnt` (wraps to 0), and go to BINARIZE.

**BINARIZE, on each `pix_valid`:**
- Next edge: `bin_out = (pix_in >= threshold)`, `bin_valid = 1`; `cnt += 1`.
- On the last pixel, go to DONE and pulse `frame_done` on the same edge as the final `bin_valid`.

**DONE:**
- `pix_valid` is ignored; outputs hold, except that strobes return to 0.
- Only `restart` or reset leaves DONE.

**Restart and reset:**
- `restart` in any state clears `sum`, `cnt` and `thr_valid`, reloads `pmin`/`pmax`, and enters ACCUM.
- `threshold` keeps its old value until overwritten.
- `restart` together with `pix_valid` in the same cycle: `restart` wins and the pixel is dropped.
- Reset mid-frame discards all partial results; `threshold` is also cleared.

## Timing
- Reset values: `bin_out` 0, `bin_valid` 0, `threshold` 0x00, `thr_valid` 0, `frame_done` 0, `busy` 1 (state ACCUM).
- All outputs are registered.
- `bin_valid` and `bin_out` are asserted one clock after the sampling edge and last exactly one cycle.
- `thr_valid` and `threshold` update on the edge that samples the last pass-1 pixel. A pass-2 pixel strobed on the very next cycle is compared against the new threshold; no bubble is required.
- `pix_valid` may be asserted every cycle (throughput 1 pixel/clock). The memory reader's one-pixel-per-two-clocks rate is supported without change.
- Gaps of any length between `pix_valid` strobes are allowed, and state is retained across them.
- `busy` drops on the same edge `frame_done` rises.

## Test plan
- **All pixels 0x80, MODE 0, strobe every 2 cycles:**
  - After 16384 strobes: `threshold` = 0x80, `thr_valid` = 1.
  - Pass 2: 16384 `bin_valid` strobes, all `bin_out` = 1.
  - `frame_done` pulses once, on the final `bin_valid`.
- **Ramp (pixel i → i & 0xFF), MODE 0:**
  - `threshold` = 0x7F, since sum = 64·32640 and >>14 gives 127.
  - Pass 2: `bin_out` = 1 exactly for values ≥ 0x7F, i.e. 129 of every 256.
- **MODE 1, all 0x10 except one pixel 0xF0:**
  - `threshold` = 0x80.
  - Same data under MODE 0 gives 0x10, since sum = 16383·16 + 240 = 262368 and >>14 gives 16.
- **Back-to-back `pix_valid` every cycle across the pass boundary:**
  - First pass-2 pixel 0x80 against threshold 0x80 → `bin_out` = 1 one cycle later.
  - No pixel is dropped; the `cnt` wrap is correct.
- **`restart` asserted together with `pix_valid` mid-pass-2 (pixel 5000):**
  - That pixel produces no `bin_valid`; `thr_valid` → 0; state returns to ACCUM.
  - A new full pass 1 of 0x20 gives `threshold` = 0x20.
- **`reset_n` low mid-pass-1, released asynchronously:**
  - All outputs read their reset values immediately.
  - Extra `pix_valid` strobes in DONE produce no `bin_valid` and no second `frame_done`.
